fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage: owns the PC, issues word reads to instruction memory over a valid/ready request
//   channel, and presents {instr, pc, pc+4} to decode over a valid/ready channel. Decode splits id_instr into
//   opcode/funct3/funct7 for control_unit. Branch/jump redirects from execute flush in-flight work.
//   Single outstanding memory request.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC loaded on reset; bits [1:0] must be 0
// PORTS
//   clk               in   1   clock, all state updates on posedge
//   rst_n             in   1   synchronous reset, active low
//   imem_req_valid    out  1   fetch request valid
//   imem_req_ready    in   1   memory accepts request this cycle
//   imem_req_addr     out  32  word-aligned fetch address (= pc)
//   imem_rsp_valid    in   1   response valid; memory has no rsp_ready, unit always accepts
//   imem_rsp_data     in   32  fetched instruction
//   redirect_valid    in   1   branch taken / jump: load redirect_pc, flush
//   redirect_pc       in   32  redirect target; bits [1:0] forced to 0 on load
//   id_valid          out  1   decode output holds a valid instruction
//   id_ready          in   1   decode consumes output this cycle
//   id_instr          out  32  instruction to decode
//   id_pc             out  32  address of id_instr
//   id_pc_plus4       out  32  id_pc + 4 (JAL/JALR link value)
// BEHAVIOUR
//   Reset (rst_n==0 at posedge): pc<=RESET_PC, state<=S_REQ, id_valid<=0, id_instr<=NOP_INSTR (32'h0000_0013),
//     id_pc<=0, id_pc_plus4<=0. imem_req_valid is 0 whenever rst_n==0. Reset mid-request abandons the request;
//     any later response is ignored until a new request is accepted.
//   States:
//     S_REQ   imem_req_valid = !id_valid || id_ready (output empty or draining). On req handshake -> S_WAIT.
//     S_WAIT  await response. On imem_rsp_valid: id_instr<=data, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1,
//             pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), -> S_REQ.
//     S_DROP  discard next response (stale after redirect). On imem_rsp_valid -> S_REQ, output untouched.
//   Output register: cleared (id_valid<=0) on id_valid&&id_ready unless loaded in the same cycle. A response
//     always lands in an empty register; the request was only issued when the register would be empty.
//   Throughput: 1 instr per 2 cycles with zero-wait memory (request cycle + response cycle).
//   Redirect (priority over everything except reset), at posedge with redirect_valid:
//     pc<=redirect_pc&~3; id_valid<=0; response arriving that cycle is discarded.
//     S_REQ without handshake -> stays S_REQ. S_REQ with handshake that cycle -> S_DROP.
//     S_WAIT without response -> S_DROP. S_WAIT or S_DROP with response -> S_REQ.
//     S_DROP without response -> stays S_DROP. Back-to-back redirects: the last one wins.
//   imem_req_addr may change while imem_req_valid=1 and imem_req_ready=0 only due to a redirect. Memory samples
//     the address at handshake.
//   No request while id_valid=1 and id_ready=0; state holds in S_REQ.
// STRUCTURE
//   riscv_pkg additions: NOP_INSTR constant (32'h0000_0013), fetch_state_t enum {S_REQ,S_WAIT,S_DROP}, XLEN=32.
//   Single module, no sub-modules; one always_ff (pc, state, output reg), one always_comb (next-state, req).
// TESTING
//   1 Reset: hold rst_n=0 3 cycles -> req_valid=0, id_valid=0, id_instr=32'h13. First cycle after release
//     -> req_valid=1, addr=RESET_PC.
//   2 Streaming: ready=1, response 1 cycle after handshake, id_ready=1, mem returns 0x00500093 @0, 0x00A00113 @4
//     -> id_pc 0,4 with matching id_instr, id_pc_plus4 4,8. One instr per 2 cycles.
//   3 Decode stall: id_ready=0 after first instr -> no new request, id_* stable. id_ready=1 -> request for
//     addr 4 in the same cycle.
//   4 Redirect in S_WAIT: redirect_pc=0x100 before response -> id_valid=0, stale response dropped, next
//     request addr 0x100, id_pc=0x100.
//   5 Redirect coincident with response, and redirect_pc=0x203 -> response discarded, next addr 0x200.
//     Two consecutive redirects 0x40 then 0x80 -> only 0x80 fetched.
//   6 Backpressure and wrap: imem_req_ready=0 for 4 cycles -> req_valid held, addr stable. Redirect to
//     32'hFFFF_FFFC -> id_pc_plus4=0, next fetch addr 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width, canonical NOP encoding and fetch FSM states.
package riscv_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight and
// hands {instr, pc, pc+4} to decode; execute redirects flush in-flight work.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4
);

   fetch_state_t    r_state;
   fetch_state_t    w_next_state;
   logic [XLEN-1:0] r_pc;
   logic            r_id_valid;
   logic [XLEN-1:0] r_id_instr;
   logic [XLEN-1:0] r_id_pc;
   logic [XLEN-1:0] r_id_pc_plus4;
   logic            w_req_valid;
   logic            w_req_hs;
   logic            w_load;

   always_comb begin
      w_next_state = r_state;
      // Only request when the output register will be free by the time the response lands.
      w_req_valid  = rst_n && (r_state == S_REQ) && (!r_id_valid || id_ready);
      w_req_hs     = w_req_valid && imem_req_ready;
      w_load       = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
      if (redirect_valid) begin
         case (r_state)
            S_REQ:   w_next_state = w_req_hs       ? S_DROP : S_REQ;
            S_WAIT:  w_next_state = imem_rsp_valid ? S_REQ  : S_DROP;
            S_DROP:  w_next_state = imem_rsp_valid ? S_REQ  : S_DROP;
            default: w_next_state = S_REQ;
         endcase
      end else begin
         case (r_state)
            S_REQ:   if (w_req_hs)       w_next_state = S_WAIT;
            S_WAIT:  if (imem_rsp_valid) w_next_state = S_REQ;
            S_DROP:  if (imem_rsp_valid) w_next_state = S_REQ;
            default: w_next_state = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_REQ;
         r_pc          <= RESET_PC;
         r_id_valid    <= 1'b0;
         r_id_instr    <= NOP_INSTR;
         r_id_pc       <= '0;
         r_id_pc_plus4 <= '0;
      end else begin
         r_state <= w_next_state;
         if (redirect_valid) begin
            r_pc       <= redirect_pc & ~32'd3;
            r_id_valid <= 1'b0;
         end else if (w_load) begin
            r_pc          <= r_pc + 32'd4;
            r_id_valid    <= 1'b1;
            r_id_instr    <= imem_rsp_data;
            r_id_pc       <= r_pc;
            r_id_pc_plus4 <= r_pc + 32'd4;
         end else if (r_id_valid && id_ready) begin
            r_id_valid <= 1'b0;
         end
      end
   end

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_pc;
   assign id_valid       = r_id_valid;
   assign id_instr       = r_id_instr;
   assign id_pc          = r_id_pc;
   assign id_pc_plus4    = r_id_pc_plus4;

endmodule
